// File: rtl/wb_line_arbiter.sv
// Two-master Wishbone cache-line arbiter: the instruction-fetch and data masters share one L2 slave.
// It grants fairly on conflict, holds each grant until ACK or abort, and keeps saturating performance counters.
module wb_line_arbiter #(
  parameter int ADR_W  = 12,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADR_W-1:0]    i_ADR,
  input  logic [LINE_W-1:0]   i_DAT_M,
  input  logic [LINE_W/8-1:0] i_SEL,
  input  logic                i_WE,
  input  logic                i_STB,
  input  logic                i_CYC,
  output logic [LINE_W-1:0]   i_DAT_S,
  output logic                i_ACK,
  input  logic [ADR_W-1:0]    d_ADR,
  input  logic [LINE_W-1:0]   d_DAT_M,
  input  logic [LINE_W/8-1:0] d_SEL,
  input  logic                d_WE,
  input  logic                d_STB,
  input  logic                d_CYC,
  output logic [LINE_W-1:0]   d_DAT_S,
  output logic                d_ACK,
  output logic [ADR_W-1:0]    s_ADR,
  output logic [LINE_W-1:0]   s_DAT_M,
  output logic [LINE_W/8-1:0] s_SEL,
  output logic                s_WE,
  output logic                s_STB,
  output logic                s_CYC,
  input  logic [LINE_W-1:0]   s_DAT_S,
  input  logic                s_ACK,
  input  logic                clr_counters,
  output logic [CNT_W-1:0]    i_grant_cnt,
  output logic [CNT_W-1:0]    d_grant_cnt,
  output logic [CNT_W-1:0]    d_wait_cnt
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_e;
  typedef enum logic {MASTER_I, MASTER_D} master_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           r_state;
  master_e          r_lastServed;
  logic [CNT_W-1:0] r_iGrantCnt;
  logic [CNT_W-1:0] r_dGrantCnt;
  logic [CNT_W-1:0] r_dWaitCnt;

  logic w_iReq;
  logic w_dReq;
  logic w_iAck;
  logic w_dAck;

  assign w_iReq = i_CYC & i_STB;
  assign w_dReq = d_CYC & d_STB;
  assign w_iAck = (r_state == SERVE_I) & s_ACK & w_iReq;
  assign w_dAck = (r_state == SERVE_D) & s_ACK & w_dReq;

  assign i_ACK   = w_iAck;
  assign d_ACK   = w_dAck;
  assign i_DAT_S = s_DAT_S;
  assign d_DAT_S = s_DAT_S;

  // The granted master's request passes straight through; in IDLE the slave sees an all-zero bus.
  always_comb begin
    s_ADR   = '0;
    s_DAT_M = '0;
    s_SEL   = '0;
    s_WE    = 1'b0;
    s_STB   = 1'b0;
    s_CYC   = 1'b0;
    case (r_state)
      SERVE_I: begin
        s_ADR   = i_ADR;
        s_DAT_M = i_DAT_M;
        s_SEL   = i_SEL;
        s_WE    = i_WE;
        s_STB   = i_STB;
        s_CYC   = i_CYC;
      end
      SERVE_D: begin
        s_ADR   = d_ADR;
        s_DAT_M = d_DAT_M;
        s_SEL   = d_SEL;
        s_WE    = d_WE;
        s_STB   = d_STB;
        s_CYC   = d_CYC;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_lastServed <= MASTER_I;
    end else begin
      case (r_state)
        IDLE: begin
          // On a conflict the master that was not served last wins.
          if (w_dReq && (!w_iReq || r_lastServed == MASTER_I)) begin
            r_state      <= SERVE_D;
            r_lastServed <= MASTER_D;
          end else if (w_iReq) begin
            r_state      <= SERVE_I;
            r_lastServed <= MASTER_I;
          end
        end
        SERVE_I: if (w_iAck || !i_CYC) r_state <= IDLE;
        SERVE_D: if (w_dAck || !d_CYC) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Counters saturate at all-ones; a clear overrides any increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iGrantCnt <= '0;
      r_dGrantCnt <= '0;
      r_dWaitCnt  <= '0;
    end else if (clr_counters) begin
      r_iGrantCnt <= '0;
      r_dGrantCnt <= '0;
      r_dWaitCnt  <= '0;
    end else begin
      if (w_iAck && r_iGrantCnt != CNT_MAX) r_iGrantCnt <= r_iGrantCnt + CNT_ONE;
      if (w_dAck && r_dGrantCnt != CNT_MAX) r_dGrantCnt <= r_dGrantCnt + CNT_ONE;
      if (w_dReq && !w_dAck && r_dWaitCnt != CNT_MAX) r_dWaitCnt <= r_dWaitCnt + CNT_ONE;
    end
  end

  assign i_grant_cnt = r_iGrantCnt;
  assign d_grant_cnt = r_dGrantCnt;
  assign d_wait_cnt  = r_dWaitCnt;

endmodule

// File: tb/tb_wb_line_arbiter.sv
// Directed bench for wb_line_arbiter; a second instance with 2-bit counters shares the stimulus
// so that counter saturation can be reached within a few transactions.
module tb_wb_line_arbiter;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [11:0]   i_ADR, d_ADR;
  logic [127:0]  i_DAT_M, d_DAT_M;
  logic [15:0]   i_SEL, d_SEL;
  logic          i_WE, i_STB, i_CYC, d_WE, d_STB, d_CYC;
  logic [127:0]  i_DAT_S, d_DAT_S;
  logic          i_ACK, d_ACK;
  logic [11:0]   s_ADR;
  logic [127:0]  s_DAT_M;
  logic [15:0]   s_SEL;
  logic          s_WE, s_STB, s_CYC;
  logic [127:0]  s_DAT_S;
  logic          s_ACK;
  logic          clr_counters;
  logic [15:0]   i_grant_cnt, d_grant_cnt, d_wait_cnt;

  logic [127:0]  smallIDatS, smallDDatS, smallSDatM;
  logic          smallIAck, smallDAck, smallSWe, smallSStb, smallSCyc;
  logic [11:0]   smallSAdr;
  logic [15:0]   smallSSel;
  logic [1:0]    smallIGrant, smallDGrant, smallDWait;

  int nChecks = 0;
  int nFails  = 0;
  int expI, expD, expWait;

  always #5 clk = ~clk;

  wb_line_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_ADR(i_ADR), .i_DAT_M(i_DAT_M), .i_SEL(i_SEL), .i_WE(i_WE), .i_STB(i_STB), .i_CYC(i_CYC),
    .i_DAT_S(i_DAT_S), .i_ACK(i_ACK),
    .d_ADR(d_ADR), .d_DAT_M(d_DAT_M), .d_SEL(d_SEL), .d_WE(d_WE), .d_STB(d_STB), .d_CYC(d_CYC),
    .d_DAT_S(d_DAT_S), .d_ACK(d_ACK),
    .s_ADR(s_ADR), .s_DAT_M(s_DAT_M), .s_SEL(s_SEL), .s_WE(s_WE), .s_STB(s_STB), .s_CYC(s_CYC),
    .s_DAT_S(s_DAT_S), .s_ACK(s_ACK),
    .clr_counters(clr_counters),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .d_wait_cnt(d_wait_cnt)
  );

  wb_line_arbiter #(.CNT_W(2)) dutSmall (
    .clk(clk), .rst_n(rst_n),
    .i_ADR(i_ADR), .i_DAT_M(i_DAT_M), .i_SEL(i_SEL), .i_WE(i_WE), .i_STB(i_STB), .i_CYC(i_CYC),
    .i_DAT_S(smallIDatS), .i_ACK(smallIAck),
    .d_ADR(d_ADR), .d_DAT_M(d_DAT_M), .d_SEL(d_SEL), .d_WE(d_WE), .d_STB(d_STB), .d_CYC(d_CYC),
    .d_DAT_S(smallDDatS), .d_ACK(smallDAck),
    .s_ADR(smallSAdr), .s_DAT_M(smallSDatM), .s_SEL(smallSSel), .s_WE(smallSWe), .s_STB(smallSStb),
    .s_CYC(smallSCyc),
    .s_DAT_S(s_DAT_S), .s_ACK(s_ACK),
    .clr_counters(clr_counters),
    .i_grant_cnt(smallIGrant), .d_grant_cnt(smallDGrant), .d_wait_cnt(smallDWait)
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic waitCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit isD, input logic [11:0] adr, input logic we,
                               input logic [15:0] sel, input logic cyc, input logic stb);
    if (isD) begin
      d_ADR = adr; d_WE = we; d_SEL = sel; d_CYC = cyc; d_STB = stb; d_DAT_M = {8{adr, 4'hD}};
    end else begin
      i_ADR = adr; i_WE = we; i_SEL = sel; i_CYC = cyc; i_STB = stb; i_DAT_M = {8{adr, 4'hA}};
    end
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_counters = 1'b0;
    s_ACK = 1'b0;
    s_DAT_S = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    applyStimulus(1'b0, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b0);
    #3;
    checkOutput("rst s_STB", s_STB, 0);
    checkOutput("rst s_CYC", s_CYC, 0);
    checkOutput("rst i_ACK", i_ACK, 0);
    checkOutput("rst d_ACK", d_ACK, 0);
    checkOutput("rst counters", {i_grant_cnt, d_grant_cnt, d_wait_cnt}, 0);
    #9;
    rst_n = 1'b1;

    // Single instruction fetch, slave acks two cycles after STB.
    waitCycle();
    applyStimulus(1'b0, 12'h010, 1'b0, 16'hFFFF, 1'b1, 1'b1);
    #1 checkOutput("t1 idle s_STB", s_STB, 0);
    waitCycle();
    #1 checkOutput("t1 s_ADR", s_ADR, 12'h010);
    checkOutput("t1 s_STB", s_STB, 1);
    checkOutput("t1 early i_ACK", i_ACK, 0);
    waitCycle();
    waitCycle();
    s_ACK = 1'b1;
    #1 checkOutput("t1 i_ACK", i_ACK, 1);
    checkOutput("t1 i_DAT_S", i_DAT_S, s_DAT_S);
    checkOutput("t1 d_ACK", d_ACK, 0);
    waitCycle();
    s_ACK = 1'b0;
    applyStimulus(1'b0, 12'h010, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    #1 checkOutput("t1 i_ACK pulse", i_ACK, 0);
    checkOutput("t1 i_grant_cnt", i_grant_cnt, 1);
    checkOutput("t1 back idle", s_CYC, 0);

    // Simultaneous requests after reset: D first, then I after one bubble.
    resetDut();
    waitCycle();
    applyStimulus(1'b0, 12'h020, 1'b0, 16'hFFFF, 1'b1, 1'b1);
    applyStimulus(1'b1, 12'h030, 1'b0, 16'hFFFF, 1'b1, 1'b1);
    waitCycle();
    #1 checkOutput("t2 D first", s_ADR, 12'h030);
    s_ACK = 1'b1;
    #1 checkOutput("t2 d_ACK", d_ACK, 1);
    checkOutput("t2 i not acked", i_ACK, 0);
    waitCycle();
    s_ACK = 1'b0;
    applyStimulus(1'b1, 12'h030, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    #1 checkOutput("t2 bubble", s_STB, 0);
    checkOutput("t2 d_grant_cnt", d_grant_cnt, 1);
    waitCycle();
    #1 checkOutput("t2 I second", s_ADR, 12'h020);
    s_ACK = 1'b1;
    #1 checkOutput("t2 i_ACK", i_ACK, 1);
    waitCycle();
    s_ACK = 1'b0;
    applyStimulus(1'b0, 12'h020, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    #1 checkOutput("t2 i_grant_cnt", i_grant_cnt, 1);
    checkOutput("t2 d_wait_cnt", d_wait_cnt, 1);

    // Continuous contention: grants alternate D,I,D,I,D,I.
    resetDut();
    waitCycle();
    applyStimulus(1'b0, 12'h0A0, 1'b0, 16'hFFFF, 1'b1, 1'b1);
    applyStimulus(1'b1, 12'h0D0, 1'b0, 16'hFFFF, 1'b1, 1'b1);
    expI = 0; expD = 0; expWait = 0;
    for (int k = 0; k < 6; k++) begin
      waitCycle();
      #1 checkOutput($sformatf("t3 grant %0d", k), s_ADR, (k % 2 == 0) ? 12'h0D0 : 12'h0A0);
      waitCycle();
      s_ACK = 1'b1;
      #1 checkOutput($sformatf("t3 ack %0d", k), {i_ACK, d_ACK}, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k % 2 == 0) begin
        expD++;
        expWait += 2;
      end else begin
        expI++;
        expWait += 3;
      end
      waitCycle();
      s_ACK = 1'b0;
      #1 checkOutput($sformatf("t3 counts %0d", k), {i_grant_cnt, d_grant_cnt}, {expI[15:0], expD[15:0]});
    end
    applyStimulus(1'b0, 12'h0A0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(1'b1, 12'h0D0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    #1 checkOutput("t3 d_wait_cnt", d_wait_cnt, expWait);

    // Data write aborted mid-wait, then a stray slave ACK while idle.
    resetDut();
    waitCycle();
    applyStimulus(1'b1, 12'h055, 1'b1, 16'h0030, 1'b1, 1'b1);
    waitCycle();
    #1 checkOutput("t4 s_WE", s_WE, 1);
    checkOutput("t4 s_SEL", s_SEL, 16'h0030);
    checkOutput("t4 s_DAT_M", s_DAT_M, {8{12'h055, 4'hD}});
    waitCycle();
    d_CYC = 1'b0;
    #1 checkOutput("t4 s_CYC drop", s_CYC, 0);
    checkOutput("t4 no d_ACK", d_ACK, 0);
    waitCycle();
    d_STB = 1'b0;
    s_ACK = 1'b1;
    #1 checkOutput("t4 idle acks", {i_ACK, d_ACK}, 0);
    checkOutput("t4 idle s_STB", s_STB, 0);
    waitCycle();
    s_ACK = 1'b0;
    #1 checkOutput("t4 d_grant_cnt", d_grant_cnt, 0);
    checkOutput("t4 i_grant_cnt", i_grant_cnt, 0);

    // Asynchronous reset in the middle of an instruction fetch.
    resetDut();
    waitCycle();
    applyStimulus(1'b0, 12'h077, 1'b0, 16'hFFFF, 1'b1, 1'b1);
    waitCycle();
    #1 checkOutput("t5 s_STB before", s_STB, 1);
    rst_n = 1'b0;
    #1 checkOutput("t5 s_STB in reset", s_STB, 0);
    checkOutput("t5 counters", {i_grant_cnt, d_grant_cnt, d_wait_cnt}, 0);
    #1 rst_n = 1'b1;
    waitCycle();
    #1 checkOutput("t5 regrant", s_ADR, 12'h077);
    s_ACK = 1'b1;
    waitCycle();
    s_ACK = 1'b0;
    applyStimulus(1'b0, 12'h077, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    #1 checkOutput("t5 i_grant_cnt", i_grant_cnt, 1);

    // Saturation on the 2-bit instance, then clear beating a same-cycle ACK.
    resetDut();
    waitCycle();
    applyStimulus(1'b1, 12'h0E0, 1'b0, 16'hFFFF, 1'b1, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      waitCycle();
      s_ACK = 1'b1;
      waitCycle();
      s_ACK = 1'b0;
      #1 checkOutput($sformatf("t6 sat cnt %0d", k), smallDGrant, (k > 3) ? 2'd3 : 2'(k));
      checkOutput($sformatf("t6 wide cnt %0d", k), d_grant_cnt, k);
    end
    waitCycle();
    s_ACK = 1'b1;
    clr_counters = 1'b1;
    waitCycle();
    s_ACK = 1'b0;
    clr_counters = 1'b0;
    applyStimulus(1'b1, 12'h0E0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    #1 checkOutput("t6 clr wide", d_grant_cnt, 0);
    checkOutput("t6 clr small", smallDGrant, 0);
    checkOutput("t6 clr wait", d_wait_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/wb_line_arbiter.md
WB_LINE_ARBITER -- requirements
Module: wb_line_arbiter

Interface
REQ-001 Parameter ADR_W, default 12, line-address width.
REQ-002 Parameter LINE_W, default 128, cache-line data width; SEL width is LINE_W/8.
REQ-003 Parameter CNT_W, default 16, width of the grant/stall performance counters.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_ADR, i_DAT_M, i_SEL, i_WE, i_STB, i_CYC  input  ADR_W/LINE_W/LINE_W/8/1/1/1  instruction-fetch master request.
REQ-007 i_DAT_S, i_ACK  output  LINE_W/1  instruction-fetch master response.
REQ-008 d_ADR, d_DAT_M, d_SEL, d_WE, d_STB, d_CYC  input  same widths as i_*  data master request.
REQ-009 d_DAT_S, d_ACK  output  LINE_W/1  data master response.
REQ-010 s_ADR, s_DAT_M, s_SEL, s_WE, s_STB, s_CYC  output  same widths  downstream slave request (L2).
REQ-011 s_DAT_S, s_ACK  input  LINE_W/1  downstream slave response.
REQ-012 clr_counters  input  1  synchronous clear of all counters.
REQ-013 i_grant_cnt, d_grant_cnt, d_wait_cnt  output  CNT_W each  completed i-transactions, completed d-transactions, cycles d_CYC&d_STB asserted without d_ACK.

Function
REQ-014 FSM states IDLE, SERVE_I, SERVE_D; exactly one state active; reset state IDLE.
REQ-015 A master requests when its CYC and STB are both 1.
REQ-016 In IDLE, one request: move to that master's SERVE state next cycle.
REQ-017 In IDLE, both requesting: grant the master not served last; last_served register resets to I, so the first conflict grants D.
REQ-018 last_served updates on entry to SERVE_I/SERVE_D.
REQ-019 In SERVE_x, s_ADR/s_DAT_M/s_SEL/s_WE/s_STB/s_CYC combinationally equal master x's inputs; in IDLE all s_* outputs are 0.
REQ-020 s_DAT_S drives both i_DAT_S and d_DAT_S; s_ACK routes only to the granted master's ACK, gated by that master's CYC&STB; the other ACK is 0.
REQ-021 In SERVE_x, s_ACK=1: complete; next state IDLE; granted counter increments; one IDLE bubble precedes every new grant.
REQ-022 Minimum latency: request seen in IDLE at cycle N; s_STB=1 at N+1; earliest master ACK at N+1 if the slave acks combinationally.
REQ-023 In SERVE_x, master x drops CYC before s_ACK (abort): s_CYC=0 the same cycle; next state IDLE; no counter increments.
REQ-024 Once granted, a master holds the bus until ACK or abort; the other master's requests are ignored (no preemption).
REQ-025 Requests to the non-granted master are never acknowledged; that master stalls by holding STB.
REQ-026 d_wait_cnt increments each cycle d_CYC&d_STB=1 and d_ACK=0, in any state.
REQ-027 Counters saturate at all-ones and do not wrap.
REQ-028 clr_counters has priority over same-cycle increments; counters read 0 the next cycle.
REQ-029 s_ACK while IDLE is ignored: no state change, no counter change, no master ACK.

Reset
REQ-030 rst_n=0 forces IDLE, last_served=I, all counters 0, and all s_* and master ACK outputs 0 immediately, without waiting for clk.
REQ-031 Reset during SERVE_x abandons the transaction; after release the arbiter re-arbitrates from IDLE and replays nothing.

Verification
REQ-032 Single i request, ADR=12'h010, slave acks 2 cycles after STB -> s_ADR=12'h010 one cycle after request; i_ACK pulses 1 cycle; i_grant_cnt=1; then IDLE.
REQ-033 i and d request the same cycle after reset -> D served first; I served after D's ACK plus one bubble; d_grant_cnt=1, i_grant_cnt=1.
REQ-034 Both masters request continuously over 6 transactions with slave ack latency 1 -> grants strictly alternate D,I,D,I,D,I; d_wait_cnt equals the summed stall cycles.
REQ-035 d write WE=1, SEL=16'h0030, d aborts CYC mid-wait -> s_CYC drops the same cycle; no d_ACK; d_grant_cnt unchanged.
REQ-036 rst_n asserted mid SERVE_I between clock edges -> s_STB=0 before the next edge; counters 0; a post-reset request is granted normally.
REQ-037 Preload d_grant_cnt=16'hFFFE, complete 3 d-transactions -> d_grant_cnt=16'hFFFF; clr_counters with a same-cycle ACK -> 0.
